// File: rtl/debug_uart_fifo.sv
// Buffered debug UART transmitter: TX FIFO, runtime divider, status/overflow flags, TX-empty interrupt.
// Optional receiver with a one-entry buffer is built when DEBUG_UART_RX_EN is defined.
module debug_uart_fifo #(
  parameter int CLOCK_MHZ  = 14,
  parameter int BIT_RATE   = 1_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr_in,
  input  logic        sel,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        uart_txd,
  output logic        interrupt
`ifdef DEBUG_UART_RX_EN
  ,
  input  logic        uart_rxd
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(CLOCK_MHZ * 1_000_000 / BIT_RATE);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic wr_en, rd_en;
  logic [7:0] fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] level_q, level_d;
  logic fifo_full, fifo_empty, push, pop, load;
  logic ovf_q, ovf_d, ie_q, ie_d, rx_ovr, busy, bit_end;
  logic [DIV_WIDTH-1:0] div_q, div_d, div_lat_q, div_lat_d, clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [31:0] rx_word;
  tx_state_e tx_state_q, tx_state_d;

  assign wr_en      = sel && (data_write_n != 2'b11);
  assign rd_en      = sel && (data_read_n != 2'b11);
  assign fifo_full  = (level_q == FULL_LEVEL);
  assign fifo_empty = (level_q == '0);
  assign push       = wr_en && (addr_in == 2'd0) && !fifo_full;
  assign bit_end    = (clk_cnt_q == div_lat_q - DIV_WIDTH'(1));
  assign data_ready = 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      ie_q       <= 1'b0;
      div_q      <= DIV_RESET;
      div_lat_q  <= DIV_RESET;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      ie_q       <= ie_d;
      div_q      <= div_d;
      div_lat_q  <= div_lat_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= data_in[7:0];
  end

  // Shifter next state; every state holds for the divider value latched at frame start.
  always_comb begin
    tx_state_d = tx_state_q;
    clk_cnt_d  = clk_cnt_q + DIV_WIDTH'(1);
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    div_lat_d  = div_lat_q;
    load       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        clk_cnt_d = '0;
        load      = !fifo_empty;
      end
      TX_START: if (bit_end) begin
        tx_state_d = TX_DATA;
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
      end
      TX_DATA: if (bit_end) begin
        clk_cnt_d = '0;
        shreg_d   = {1'b1, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (bit_end) begin
        clk_cnt_d  = '0;
        tx_state_d = TX_IDLE;
        load       = !fifo_empty;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (load) begin
      tx_state_d = TX_START;
      clk_cnt_d  = '0;
      shreg_d    = fifo_mem_q[rd_ptr_q];
      div_lat_d  = div_q;
    end
  end

  always_comb begin
    pop      = load;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q;
    if (push && !pop) level_d = level_q + (PW+1)'(1);
    else if (pop && !push) level_d = level_q - (PW+1)'(1);
    ovf_d = (wr_en && addr_in == 2'd0 && fifo_full) ||
            (ovf_q && !(wr_en && addr_in == 2'd1 && data_in[3]));
    ie_d  = (wr_en && addr_in == 2'd3) ? data_in[0] : ie_q;
    div_d = div_q;
    if (wr_en && addr_in == 2'd2)
      div_d = (data_in[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : data_in[DIV_WIDTH-1:0];
  end

  always_comb begin
    busy      = !fifo_empty || (tx_state_q != TX_IDLE);
    interrupt = ie_q && fifo_empty && (tx_state_q == TX_IDLE);
    uart_txd  = 1'b1;
    if (tx_state_q == TX_START) uart_txd = 1'b0;
    else if (tx_state_q == TX_DATA) uart_txd = shreg_q[0];
  end

  always_comb begin
    data_out = '0;
    case (addr_in)
      2'd0: data_out = rx_word;
      2'd1: data_out = {19'h0, 5'(level_q), 3'h0, rx_ovr, ovf_q, fifo_empty, fifo_full, busy};
      2'd2: data_out = 32'(div_q);
      default: data_out = {31'h0, ie_q};
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^data_in;

`ifdef DEBUG_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q, rx_done;
  logic rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic [7:0] rx_shreg_q, rx_shreg_d, rx_data_q, rx_data_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_bit_q   <= '0;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RESET;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_bit_q   <= rx_bit_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
    end
  end

  // Start bit is re-checked half a bit in, so later samples land mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + DIV_WIDTH'(1);
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_div_d   = rx_div_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_div_d   = div_q;
        end
      end
      RX_START: if (rx_cnt_q == (rx_div_q >> 1) - DIV_WIDTH'(1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == rx_div_q - DIV_WIDTH'(1)) begin
        rx_cnt_d   = '0;
        rx_shreg_d = {rxd_s2_q, rx_shreg_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == rx_div_q - DIV_WIDTH'(1)) begin
        rx_state_d = RX_IDLE;
        rx_done    = rxd_s2_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_done ? rx_shreg_q : rx_data_q;
    rx_valid_d = rx_done || (rx_valid_q && !(rd_en && addr_in == 2'd0));
    rx_ovr_d   = (rx_done && rx_valid_q) ||
                 (rx_ovr_q && !(wr_en && addr_in == 2'd1 && data_in[4]));
    rx_ovr     = rx_ovr_q;
    rx_word    = {23'h0, rx_valid_q, rx_data_q};
  end
`else
  logic unused_rx;
  assign unused_rx = rd_en;
  assign rx_ovr    = 1'b0;
  assign rx_word   = '0;
`endif

endmodule

// File: tb/tb_debug_uart_fifo.sv
// Self-checking bench for debug_uart_fifo: a line monitor decodes uart_txd frames against a scoreboard
// of expected (byte, divider) pairs; RX checks are included when DEBUG_UART_RX_EN is defined.
module tb_debug_uart_fifo;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr_in = 2'd0;
  logic        sel = 1'b0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready, uart_txd, interrupt;
`ifdef DEBUG_UART_RX_EN
  logic        uart_rxd = 1'b1;
`endif

  int     cyc = 0;
  int     tests_run = 0;
  int     tests_failed = 0;
  int     last_wr_cyc = 0;
  bit     mon_en = 1'b0;
  frame_t exp_q[$];
  int     start_q[$];

  debug_uart_fifo dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .sel(sel), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .uart_txd(uart_txd), .interrupt(interrupt)
`ifdef DEBUG_UART_RX_EN
    , .uart_rxd(uart_rxd)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples mid-bit using the divider expected for the frame it pops.
  initial begin
    logic prev;
    logic [7:0] got;
    frame_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !uart_txd) begin
        start_q.push_back(cyc);
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
          prev = uart_txd;
        end else begin
          e = exp_q.pop_front();
          repeat (e.div / 2) @(negedge clk);
          tests_run++;
          if (uart_txd !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL start_bit: got %b, required 0", uart_txd);
          end
          for (int i = 0; i < 8; i++) begin
            repeat (e.div) @(negedge clk);
            got[i] = uart_txd;
          end
          repeat (e.div) @(negedge clk);
          tests_run++;
          if (uart_txd !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stop_bit: got %b, required 1", uart_txd);
          end
          tests_run++;
          if (got !== e.data) begin
            tests_failed++;
            $display("[TB] FAIL frame_data: got 0x%02h, required 0x%02h", got, e.data);
          end
          prev = 1'b1;
        end
      end else begin
        prev = uart_txd;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted at cycle %0d, required completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; addr_in = a; data_in = d; data_write_n = 2'b00;
    @(negedge clk);
    sel = 1'b0; data_write_n = 2'b11;
    last_wr_cyc = cyc;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; addr_in = a; data_read_n = 2'b00;
    #1;
    d = data_out;
    @(negedge clk);
    sel = 1'b0; data_read_n = 2'b11;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int idle_cyc);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      idle_cyc = cyc;
      bus_read(2'd1, s);
      n++;
    end while (s[0] && n < budget);
    tests_run++;
    if (s[0]) begin
      tests_failed++;
      $display("[TB] FAIL idle_timeout: busy still %b after %0d cycles, required 0", s[0], budget);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (uart_txd !== 1'b1 || interrupt !== 1'b0 || data_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: txd=%b irq=%b ready=%b, required 1 0 1", uart_txd, interrupt, data_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got 0x%08h, required 0x00000004", r);
    end
    bus_read(2'd2, r);
    tests_run++;
    if (r !== 32'd14) begin
      tests_failed++;
      $display("[TB] FAIL reset_div: got %0d, required 14", r);
    end
    bus_read(2'd3, r);
    tests_run++;
    if (r !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ie: got 0x%08h, required 0", r);
    end
    bus_read(2'd0, r);
    tests_run++;
    if (r !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_txdata: got 0x%08h, required 0", r);
    end
    tests_run++;
    if (uart_txd !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_txd_idle: got %b, required 1", uart_txd);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    bit went_low;
    mon_en = 1'b0;
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h66);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (uart_txd !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_abort_txd: got %b, required 1", uart_txd);
    end
    rst_n = 1'b1;
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL reset_discard_status: got 0x%08h, required 0x00000004", r);
    end
    went_low = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) went_low = 1'b1;
    end
    tests_run++;
    if (went_low) begin
      tests_failed++;
      $display("[TB] FAIL reset_discard_line: txd left idle after reset, required steady 1");
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [31:0] r;
    int n;
    start_q.delete();
    exp_q.push_back('{8'hA5, 14});
    bus_write(2'd0, 32'hA5);
    n = last_wr_cyc;
    wait_until(n + 140);
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h5) begin
      tests_failed++;
      $display("[TB] FAIL single_busy_last: got 0x%08h, required 0x00000005", r);
    end
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL single_busy_clear: got 0x%08h, required 0x00000004", r);
    end
    tests_run++;
    if (start_q.size() != 1 || start_q[0] != n + 1) begin
      tests_failed++;
      $display("[TB] FAIL single_start_time: got %0d starts first at %0d, required 1 at %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, n + 1);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int idle;
    start_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back('{8'(i * 8'h11), 14});
    for (int i = 1; i <= 6; i++) bus_write(2'd0, 32'(i * 8'h11));
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h40B) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status: got 0x%08h, required 0x0000040b", r);
    end
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h403) begin
      tests_failed++;
      $display("[TB] FAIL ovf_clear: got 0x%08h, required 0x00000403", r);
    end
    wait_idle(1000, idle);
    tests_run++;
    if (start_q.size() != 5 || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_frame_count: got %0d frames %0d pending, required 5 frames 0 pending",
               start_q.size(), exp_q.size());
    end else begin
      tests_run++;
      if (start_q[4] - start_q[0] != 560) begin
        tests_failed++;
        $display("[TB] FAIL ovf_back_to_back: got span %0d, required 560", start_q[4] - start_q[0]);
      end
    end
  endtask

  task automatic test_div_change();
    logic [31:0] r;
    int idle;
    start_q.delete();
    bus_write(2'd2, 32'd4);
    exp_q.push_back('{8'h3C, 4});
    exp_q.push_back('{8'hC3, 2});
    bus_write(2'd0, 32'h3C);
    bus_write(2'd0, 32'hC3);
    bus_write(2'd2, 32'd2);
    wait_idle(200, idle);
    tests_run++;
    if (start_q.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL div_frame_count: got %0d, required 2", start_q.size());
    end else begin
      tests_run++;
      if (start_q[1] - start_q[0] != 40 || idle - start_q[1] != 20) begin
        tests_failed++;
        $display("[TB] FAIL div_frame_len: got %0d and %0d, required 40 and 20",
                 start_q[1] - start_q[0], idle - start_q[1]);
      end
    end
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, r);
    tests_run++;
    if (r !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL div_min_clamp: got %0d, required 2", r);
    end
    bus_write(2'd2, 32'd14);
  endtask

  task automatic test_interrupt();
    logic [31:0] r;
    int n;
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, r);
    tests_run++;
    if (r !== 32'h1 || interrupt !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL irq_enable_idle: ie=0x%08h irq=%b, required 0x00000001 1", r, interrupt);
    end
    exp_q.push_back('{8'h5A, 14});
    bus_write(2'd0, 32'h5A);
    n = last_wr_cyc;
    tests_run++;
    if (interrupt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL irq_busy_low: got %b, required 0", interrupt);
    end
    wait_until(n + 140);
    tests_run++;
    if (interrupt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL irq_stop_low: got %b, required 0", interrupt);
    end
    @(negedge clk);
    tests_run++;
    if (interrupt !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL irq_rise: got %b, required 1", interrupt);
    end
    bus_write(2'd3, 32'h0);
    tests_run++;
    if (interrupt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL irq_disable: got %b, required 0", interrupt);
    end
  endtask

`ifdef DEBUG_UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (14) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_rx();
    logic [31:0] r;
    send_rx(8'h3C, 1'b1);
    bus_read(2'd0, r);
    tests_run++;
    if (r !== 32'h13C) begin
      tests_failed++;
      $display("[TB] FAIL rx_byte: got 0x%08h, required 0x0000013c", r);
    end
    bus_read(2'd0, r);
    tests_run++;
    if (r !== 32'h03C) begin
      tests_failed++;
      $display("[TB] FAIL rx_read_clear: got 0x%08h, required 0x0000003c", r);
    end
    send_rx(8'h81, 1'b1);
    send_rx(8'h42, 1'b1);
    bus_read(2'd1, r);
    tests_run++;
    if (r !== 32'h14) begin
      tests_failed++;
      $display("[TB] FAIL rx_overrun: got 0x%08h, required 0x00000014", r);
    end
    bus_read(2'd0, r);
    tests_run++;
    if (r !== 32'h142) begin
      tests_failed++;
      $display("[TB] FAIL rx_overwrite: got 0x%08h, required 0x00000142", r);
    end
    bus_write(2'd1, 32'h10);
    send_rx(8'h77, 1'b0);
    bus_read(2'd0, r);
    tests_run++;
    if (r[8] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rx_bad_stop: got valid %b, required 0", r[8]);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    mon_en = 1'b1;
    test_reset_mid_frame();
    test_single_byte();
    test_overflow();
    test_div_change();
    test_interrupt();
`ifdef DEBUG_UART_RX_EN
    test_rx();
`endif
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/debug_uart_fifo.md
# debug_uart_fifo

Memory-mapped debug UART transmitter for the tinyQV top level. It replaces the fixed-rate, single-byte debug UART TX with a buffered transmitter: a FIFO of parametrised depth, a runtime-programmable bit divider, status and overflow flags, and a TX-empty interrupt. It decodes the `PERI_DEBUG_UART` / `PERI_DEBUG_UART_STATUS` address window via `addr_in[3:2]`, drives `uo_out[6]`, and feeds one bit of `interrupt_req`.

## Interface
- `CLOCK_MHZ`, default 14: system clock in MHz.
- `BIT_RATE`, default 1_000_000: reset-time bit rate in bit/s.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, 2..16.
- `DIV_WIDTH`, default 8: width of the divider register.
- `clk`  in  1: system clock; all state on its rising edge.
- `rst_n`  in  1: reset; **synchronous, active-low**.
- `addr_in`  in  2: register select, driven from `addr[3:2]`.
- `sel`  in  1: block selected by the top-level decode.
- `data_in`  in  32: write data.
- `data_write_n`  in  2: a write occurs when this is not 2'b11 and `sel` is high.
- `data_read_n`  in  2: a read occurs when this is not 2'b11 and `sel` is high.
- `data_out`  out  32: combinational read data.
- `data_ready`  out  1: constant 1.
- `uart_txd`  out  1: serial output; idles at 1.
- `interrupt`  out  1: TX-empty interrupt, level-sensitive.

## Operation
- **Reg 0, TXDATA.**
  - A write pushes `data_in[7:0]` into the FIFO.
  - A write while the FIFO is full is dropped and sets `ovf`. This applies even if a pop happens in the same cycle.
  - Read value: see Configuration.
- **Reg 1, STATUS.** Read format is `{19'h0, level[4:0], 3'h0, rx_ovr, ovf, empty, full, busy}`.
  - `busy` = FIFO non-empty OR shifter active.
  - Writing 1 to bit 3 clears `ovf`; writing 1 to bit 4 clears `rx_ovr`.
  - A set event and a clear in the same cycle resolve to set.
- **Reg 2, DIV.** Clocks per bit.
  - Reset value: `CLOCK_MHZ*1_000_000/BIT_RATE` (14 with defaults).
  - Written values below 2 are stored as 2.
  - Read returns the value zero-extended.
- **Reg 3, IE.** Bit 0 enables the interrupt; all other read bits are 0. Reset value 0.
- `interrupt` = `IE[0]` & FIFO empty & shifter idle.
- **Shifter states.**
  - IDLE → START when the FIFO is non-empty; the FIFO is popped and the divider value is latched.
  - START → DATA0..DATA7 (LSB first) → STOP.
  - STOP → START directly if the FIFO is non-empty, otherwise → IDLE.
  - Every state lasts exactly the latched divider value in clocks.
- **Divider writes mid-frame** take effect from the next frame only.
- **FIFO** uses wrap-around read/write pointers and a level counter that saturates exactly at `FIFO_DEPTH`. A push and a pop in the same cycle leave the level unchanged.
- **Reset values:**
  - `uart_txd`=1, `interrupt`=0, FIFO empty, `ovf`=0, `rx_ovr`=0.
  - Shifter in IDLE, `data_ready`=1.
  - Reset mid-frame aborts the frame immediately (`uart_txd`=1 in the next cycle) and discards the FIFO contents.

## Timing
- **Write to start bit:** for a write captured at edge N with the FIFO empty and the shifter idle:
  - the FIFO becomes non-empty after edge N;
  - the shifter loads at edge N+1;
  - `uart_txd` falls after edge N+1.
- **Frame length:** 10×DIV clocks. Back-to-back frames have zero idle gap.
- **Status visibility:** `full`, `level` and `ovf` reflect a write from the cycle after it.
- **`data_out`:** combinational from `addr_in` and current state; zero wait states.

## Configuration
- **Macro:** `DEBUG_UART_RX_EN`.
- **When defined:**
  - Adds input `uart_rxd` (1 bit) with a 2-flop synchroniser.
  - Receiver behaviour:
    - a falling edge starts reception;
    - the start bit is re-checked after DIV/2 clocks, and a false start returns to idle;
    - 8 data bits are then sampled every DIV clocks;
    - a stop bit that samples 0 discards the byte.
  - A received byte goes into a 1-entry buffer.
    - Reg 0 read returns `{23'h0, rx_valid, rx_data}`.
    - A read of reg 0 clears `rx_valid` at that edge.
    - A new byte arriving while `rx_valid`=1 overwrites the buffer and sets `rx_ovr`.
- **When undefined:** no RX logic and no `uart_rxd` port; reg 0 reads 0; `rx_ovr` reads 0.

## Test plan
- **Reset defaults:** release reset, read STATUS → 0x00000004; read DIV → 14; `uart_txd`=1 throughout.
- **Single byte:** write 0xA5 to TXDATA with DIV=14 → start bit begins 1 cycle after the write, bits 1,0,1,0,0,1,0,1 then stop, 140 clocks total, `busy` clears afterwards.
- **FIFO full and overflow:** FIFO_DEPTH=4, write 6 bytes in consecutive cycles → 5 frames sent (1 in shifter + 4 FIFO), 6th byte dropped, `ovf`=1; writing 0x8 to STATUS clears `ovf`.
- **Divider change mid-frame:** set DIV=4, write 2 bytes, set DIV=2 during frame 1 → frame 1 lasts 40 clocks, frame 2 lasts 20 clocks, no gap between them; writing 0 to DIV reads back 2.
- **Interrupt:** IE=1, send one byte → `interrupt`=0 while busy, rises in the cycle after the stop bit ends; IE=0 → deasserts.
- **RX** (`DEBUG_UART_RX_EN`): drive 0x3C at DIV=14 → `rx_valid`=1, reg 0 reads 0x13C and the read clears it; a second byte before the read sets `rx_ovr`; a bad stop bit leaves `rx_valid`=0.
